glb_stream_framer: RTL and testbench

Synthesizable framer that sits directly upstream of the GLB read sink. It collects a block of 16-bit words from a core-side ready/valid stream into a local buffer. When the block closes, it emits that block on the GLB-side 17-bit port as a length header followed by the payload, under ready/valid. This length-prefixed format is what the GLB read consumer expects: the first accepted word is the size, then exactly size data words.

---
 rtl/glb_stream_framer.sv | 139 +++++++++++++
 tb/tb_glb_stream_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/glb_stream_framer.sv
// Collects a block of 16-bit words from the core, then emits it as a length header plus payload.
// Optional blocks_sent frame counter is enabled by defining GLB_FRAMER_STATS_EN.
module glb_stream_framer #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_close,
    output logic        in_ready,
    output logic [16:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
`ifdef GLB_FRAMER_STATS_EN
    ,
    output logic [15:0] blocks_sent
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = CW - 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HDR   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] wr_cnt_d;
    logic [CW-1:0] rd_ptr_q;
    logic          overflow_q;
    logic [15:0]   mem_q [DEPTH];

    logic          acc;
    logic          fill_full;
    logic          closing;
    logic          last_rd;
    logic [15:0]   cnt16;

    assign in_ready  = rst_n && (state_q == FILL);
    assign acc       = in_valid && in_ready;
    assign wr_cnt_d  = wr_cnt_q + CW'(acc);
    assign fill_full = acc && (wr_cnt_d == CW'(DEPTH));
    assign closing   = (acc && in_last) || in_close || fill_full;
    assign last_rd   = (rd_ptr_q == wr_cnt_q - CW'(1));
    assign cnt16     = 16'(wr_cnt_q);
    assign overflow  = overflow_q;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        unique case (state_q)
            HDR: begin
                out_valid = 1'b1;
                out_data  = {wr_cnt_q == '0, cnt16};
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = {last_rd, mem_q[rd_ptr_q[AW-1:0]]};
            end
            default: ;
        endcase
    end

    // Buffer is never reset; wr_cnt/rd_ptr define which entries are live.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_q[wr_cnt_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    wr_cnt_q <= wr_cnt_d;
                    if (closing) begin
                        state_q  <= HDR;
                        rd_ptr_q <= '0;
                    end
                    if (fill_full && !in_last && !in_close) begin
                        overflow_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        state_q <= (wr_cnt_q != '0) ? DRAIN : FILL;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                        if (last_rd) begin
                            wr_cnt_q <= '0;
                            state_q  <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef GLB_FRAMER_STATS_EN
    logic [15:0] blocks_q;
    logic        frame_done;

    assign frame_done = out_ready &&
                        ((state_q == HDR && wr_cnt_q == '0) ||
                         (state_q == DRAIN && last_rd));
    assign blocks_sent = blocks_q;

    // Only rst_n clears the counter; a flushed frame never completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blocks_q <= '0;
        end else if (!flush && frame_done) begin
            blocks_q <= blocks_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glb_stream_framer.sv
// Directed bench for glb_stream_framer at DEPTH=1024.
// Define GLB_FRAMER_STATS_EN to also check blocks_sent.
module tb_glb_stream_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_close;
    logic        in_ready;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
`ifdef GLB_FRAMER_STATS_EN
    logic [15:0] blocks_sent;
`endif

    int checks = 0;
    int failures = 0;

    glb_stream_framer #(.DEPTH(1024)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_close(in_close),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow)
`ifdef GLB_FRAMER_STATS_EN
        ,
        .blocks_sent(blocks_sent)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic l,
                        input logic c);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        in_close = c;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_close = 1'b0;
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 37 + 16'h1234);
    endfunction

    initial begin
        int sent;
        int idx;
        logic acc;
        logic hs;
        logic [16:0] exp;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_close  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        push(16'h0011, 1'b0, 1'b0);
        push(16'h0022, 1'b0, 1'b0);
        push(16'h0033, 1'b1, 1'b0);
        chk("basic_hdr", out_data, 17'h00003);
        chk("basic_hdr_v", out_valid, 1);
        chk("basic_rdy0", in_ready, 0);
        step();
        chk("basic_w0", out_data, 17'h00011);
        chk("basic_rdy1", in_ready, 0);
        step();
        chk("basic_w1", out_data, 17'h00022);
        chk("basic_rdy2", in_ready, 0);
        step();
        chk("basic_w2", out_data, 17'h10033);
        chk("basic_rdy3", in_ready, 0);
        step();
        chk("basic_end_v", out_valid, 0);
        chk("basic_end_rdy", in_ready, 1);

        in_close = 1'b1;
        step();
        in_close = 1'b0;
        chk("empty_hdr", out_data, 17'h10000);
        chk("empty_v", out_valid, 1);
        step();
        chk("empty_end_v", out_valid, 0);
        chk("empty_end_rdy", in_ready, 1);

        push(16'h0055, 1'b0, 1'b1);
        chk("close_word_hdr", out_data, 17'h00001);
        step();
        chk("close_word_w", out_data, 17'h10055);
        step();
        chk("close_word_end", out_valid, 0);

        push(16'h0066, 1'b1, 1'b1);
        chk("last_close_hdr", out_data, 17'h00001);
        step();
        chk("last_close_w", out_data, 17'h10066);
        step();
        chk("last_close_single", out_valid, 0);
        chk("pre_ovf", overflow, 0);

        sent = 0;
        for (int cyc = 0; cyc < 6000 && sent < 1024; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = pat(sent);
            acc      = in_valid && in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("fill_done", sent, 1024);
        chk("ovf_set", overflow, 1);

        idx = 0;
        for (int cyc = 0; cyc < 6000 && idx <= 1024; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (idx == 0) exp = 17'h00400;
            else exp = {idx == 1024, pat(idx - 1)};
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp);
            chk("bp_in_ready", in_ready, 0);
            hs = out_ready && out_valid;
            step();
            if (hs) idx++;
        end
        out_ready = 1'b1;
        chk("drain_done", idx, 1025);
        chk("bp_end_v", out_valid, 0);
        chk("ovf_held", overflow, 1);
`ifdef GLB_FRAMER_STATS_EN
        chk("stats5", blocks_sent, 5);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ovf_flushed", overflow, 0);

        push(16'h00a1, 1'b0, 1'b0);
        push(16'h00a2, 1'b0, 1'b0);
        push(16'h00a3, 1'b0, 1'b0);
        push(16'h00a4, 1'b1, 1'b0);
        chk("fl_hdr", out_data, 17'h00004);
        step();
        chk("fl_w0", out_data, 17'h000a1);
        step();
        chk("fl_w1", out_data, 17'h000a2);
        step();
        chk("fl_w2", out_data, 17'h000a3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_v", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
`ifdef GLB_FRAMER_STATS_EN
        chk("stats_flush", blocks_sent, 5);
`endif
        push(16'hbeef, 1'b1, 1'b0);
        chk("fl_next_hdr", out_data, 17'h00001);
        step();
        chk("fl_next_w", out_data, 17'h1beef);
        step();
        chk("fl_next_end", out_valid, 0);
`ifdef GLB_FRAMER_STATS_EN
        chk("stats6", blocks_sent, 6);
`endif

        out_ready = 1'b0;
        push(16'h0777, 1'b1, 1'b0);
        chk("mrst_hdr", out_data, 17'h00001);
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy_low", in_ready, 0);
        step();
        chk("mrst_v", out_valid, 0);
        chk("mrst_data", out_data, 0);
`ifdef GLB_FRAMER_STATS_EN
        chk("mrst_stats", blocks_sent, 0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrst_rdy", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
